// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// One requester is granted at a time. Each grant lasts at most MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       addr0,
  output logic       addr1,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_grant;
  logic             r_busy;
  logic             r_preempt;

  logic [1:0]       w_pick;
  logic [1:0]       w_idx;
  logic             w_found;
  logic             w_expire;
  logic             w_release;

  // First set request bit, scanning upward from the priority pointer with wrap.
  always_comb begin
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_expire  = (r_hold_cnt == HOLD_LAST);
  assign w_release = done | ~req[r_sel] | w_expire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_sel      <= 2'd0;
      r_hold_cnt <= '0;
      r_grant    <= 4'b0000;
      r_busy     <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_preempt <= 1'b0;
          if (|req) begin
            r_sel      <= w_pick;
            r_grant    <= 4'b0001 << w_pick;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            // Select lines keep the last index; only the grant is withdrawn.
            r_grant   <= 4'b0000;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
            r_ptr     <= r_sel + 2'd1;
            r_preempt <= ~done & req[r_sel];
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            r_preempt  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign addr0   = r_sel[0];
  assign addr1   = r_sel[1];
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vectors, an ownership-level reference model
// compared every cycle, and hand-computed literal expectations.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       addr0, addr1, busy, preempt;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .grant(grant), .addr0(addr0), .addr1(addr1), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the mux, how many cycles it has owned it, next priority.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_addr  = 0;
  bit m_pre   = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_owner = -1; m_held = 0; m_ptr = 0; m_addr = 0; m_pre = 1'b0;
      end else if (m_owner < 0) begin
        m_pre = 1'b0;
        if (req != 4'b0000) begin
          for (int k = 0; k < 4; k++)
            if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
          m_held = 1;
          m_addr = m_owner;
        end
      end else begin
        if (done || !req[m_owner] || m_held == MAX_HOLD) begin
          m_pre   = !done && req[m_owner];
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end else begin
          m_held  = m_held + 1;
          m_pre   = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [3:0] exp_grant;
    exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("model grant",   grant, exp_grant);
    check("model busy",    {3'b000, busy}, {3'b000, (m_owner >= 0)});
    check("model preempt", {3'b000, preempt}, {3'b000, m_pre});
    check("model addr",    {2'b00, addr1, addr0}, 4'(m_addr));
    check("onehot grant",  {3'b000, $onehot0(grant)}, 4'b0001);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cmp_model();
  endtask

  function automatic logic [3:0] addr_v();
    return {2'b00, addr1, addr0};
  endfunction

  initial begin
    logic [3:0] oh_prev, oh_k;
    int prev;
    int seq [4] = '{1, 2, 3, 0};

    // Reset with all requests pending
    reset_n = 1'b0; req = 4'b1111; done = 1'b0;
    tick(); tick();
    check("rst grant", grant, 4'b0000);
    check("rst addr", addr_v(), 4'd0);
    check("rst busy", {3'b000, busy}, 4'b0000);
    check("rst preempt", {3'b000, preempt}, 4'b0000);
    reset_n = 1'b1;
    tick();
    check("post-rst grant", grant, 4'b0001);
    check("post-rst addr", addr_v(), 4'd0);

    // Rotation with done in each grant's second cycle
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      oh_prev = 4'b0001 << prev;
      oh_k    = 4'b0001 << seq[i];
      done = 1'b0; tick();
      check("rot hold", grant, oh_prev);
      done = 1'b1; tick();
      check("rot gap", grant, 4'b0000);
      check("rot no preempt", {3'b000, preempt}, 4'b0000);
      done = 1'b0; tick();
      check("rot next", grant, oh_k);
      check("rot addr", addr_v(), 4'(seq[i]));
      prev = seq[i];
    end

    // Hold expiry: ptr is 1 after the release of requester 0
    req = 4'b0000; tick();
    check("drop release", grant, 4'b0000);
    req = 4'b0101; tick();
    check("exp first", grant, 4'b0100);
    check("exp addr", addr_v(), 4'd2);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("exp hold2", grant, 4'b0100);
    end
    tick();
    check("exp gap", grant, 4'b0000);
    check("exp preempt", {3'b000, preempt}, 4'b0001);
    tick();
    check("exp second", grant, 4'b0001);
    check("exp addr0", addr_v(), 4'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("exp hold0", grant, 4'b0001);
    end
    tick();
    check("exp gap2", grant, 4'b0000);
    check("exp preempt2", {3'b000, preempt}, 4'b0001);
    tick();
    check("exp third", grant, 4'b0100);

    // Request drop after 3 grant cycles
    req = 4'b0001; tick();
    check("drop2 release", grant, 4'b0000);
    check("drop2 preempt", {3'b000, preempt}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drop hold", grant, 4'b0001);
    end
    req = 4'b0000; tick();
    check("drop gap", grant, 4'b0000);
    check("drop preempt", {3'b000, preempt}, 4'b0000);
    done = 1'b1; tick();
    check("idle done ignored", grant, 4'b0000);
    done = 1'b0; req = 4'b1111; tick();
    check("ptr after drop", grant, 4'b0010);

    // done coinciding with hold expiry
    req = 4'b0001; tick();
    check("coin release", grant, 4'b0000);
    tick();
    check("coin first", grant, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("coin hold", grant, 4'b0001);
    end
    done = 1'b1; tick();
    check("coin gap", grant, 4'b0000);
    check("coin preempt", {3'b000, preempt}, 4'b0000);
    done = 1'b0;

    // Reset in the middle of a grant
    req = 4'b0100; tick();
    check("mid grant", grant, 4'b0100);
    tick();
    check("mid grant2", grant, 4'b0100);
    reset_n = 1'b0; tick();
    check("mid rst grant", grant, 4'b0000);
    check("mid rst addr", addr_v(), 4'd0);
    check("mid rst preempt", {3'b000, preempt}, 4'b0000);
    reset_n = 1'b1; req = 4'b1100; tick();
    check("ptr reset", grant, 4'b0100);
    check("ptr reset addr", addr_v(), 4'd2);
    req = 4'b0000; tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 structural multiplexer among four requesters. It grants one requester at a time and drives the mux select lines addr0/addr1 with the granted index. Each grant is bounded by a hold limit so that no requester can starve the others. It sits between the requesting blocks and the mux select inputs.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles a single grant may be held; legal range 1..15
CNT_W, 4, width of the internal hold counter; must hold MAX_HOLD-1

Ports:
clk  input  1  rising-edge clock; single clock domain
reset_n  input  1  synchronous, active-low reset
req  input  4  request vector; bit i = requester i wants mux input i
done  input  1  granted requester signals end of transfer; sampled only while busy
grant  output  4  one-hot grant; all zero when idle
addr0  output  1  mux select LSB (index bit 0)
addr1  output  1  mux select MSB (index bit 1)
busy  output  1  high while a grant is active; equals |grant
preempt  output  1  one-cycle pulse: the last grant was revoked by hold expiry

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset: reset_n sampled low at a rising edge gives grant=0000, addr1:addr0=00, busy=0, preempt=0, state=IDLE, hold_cnt=0, ptr=0. Applies mid-grant; an in-flight grant is dropped with no preempt pulse.
- Internal state: FSM {IDLE, GRANT}, 2-bit priority pointer ptr, CNT_W-bit hold_cnt.
- IDLE: at an edge with req!=0, select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Then set grant=onehot(sel), {addr1,addr0}=sel, busy=1, hold_cnt=0, state=GRANT. With req=0, stay in IDLE; grant stays 0 and addr holds its last value.
- Latency: req sampled at edge n gives grant visible from edge n onward (first grant cycle = cycle n+1).
- GRANT release condition at an edge is any of: done=1; req[sel]=0; hold_cnt==MAX_HOLD-1.
- On release: grant<=0, busy<=0, state<=IDLE, ptr<=(sel+1) mod 4 (3 wraps to 0). addr holds sel.
- Otherwise: hold_cnt<=hold_cnt+1, and grant/addr are unchanged.
- A grant therefore lasts at most MAX_HOLD cycles. There is at least one idle cycle between consecutive grants (bus turnaround).
- preempt<=1 at the release edge only when the cause is hold expiry alone (done=0 and req[sel]=1). It is 0 on every other edge. If done and expiry coincide, preempt=0.
- done while IDLE is ignored. req changes on non-granted bits during GRANT have no effect.
- When MAX_HOLD=1, every grant lasts exactly 1 cycle, and preempt fires whenever req[sel] stays high and done=0.
- Invariants for assertions:
  - grant is zero or one-hot.
  - busy==|grant.
  - When busy, {addr1,addr0} equals the index of the set grant bit.
  - hold_cnt<MAX_HOLD.

Test Plan:
1. Reset: reset_n=0 for 2 edges with req=1111 -> grant=0000, addr=00, busy=0, preempt=0. Then release reset -> grant=0001 and addr=00 in the next cycle.
2. Rotation and wrap: req=1111, done pulsed in each grant's 2nd cycle -> grant sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001. addr follows 00,01,10,11,00. preempt never set.
3. Hold expiry (MAX_HOLD=8): req=0101 held, done=0 -> 0001 for exactly 8 cycles, then one idle cycle with preempt=1. Then 0100 for 8 cycles (addr=10), idle with preempt=1, then 0001 again.
4. Request drop: only req[0]=1, deasserted after 3 grant cycles -> grant 0001 for 3 cycles, then 0000, ptr=1, preempt=0.
5. Coincident done and expiry: req=0001, done=1 in grant cycle 8 -> release after 8 cycles, preempt=0.
6. Reset mid-grant: grant=0100 active, reset_n=0 for one edge -> grant=0000, addr=00. Then req=1100 -> grant=0100, confirming ptr returned to 0 and index 2 wins over 3.
